hdmi_video_timing_gen: RTL and testbench

Parametrised video timing generator with a pixel-stream input, feeding the TMDS encoders inside the HDMI transmitter core. Replaces the fixed-resolution timing selected by a string. Every porch, sync width and polarity is a parameter. Adds frame-aligned start/stop control, a ready/valid pixel handshake and underflow detection. Runs on the pixel clock.

---
 rtl/hdmi_video_timing_gen.sv | 231 +++++++++++++++++++++++
 tb/tb_hdmi_video_timing_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_video_timing_gen.sv
// hdmi_video_timing_gen
//   Parametrised video timing generator that feeds the TMDS encoders of the
//   HDMI transmitter. The porches, sync widths and sync polarities are all
//   parameters. The block adds frame-aligned start/stop control, a ready/valid
//   pixel input and a sticky underflow flag. It runs on the pixel clock.
//
//   Optional build macro: HDMI_VTG_TEST_PATTERN_EN
//     Adds input i_pattern. When it is sampled high at (0,0), the whole frame
//     shows 8 vertical colour bars instead of the pixel stream.
//
// Ports
//   clk          pixel clock
//   rst          synchronous active-high reset
//   i_enable     run request
//   i_rgb        pixel data {R,G,B}
//   i_valid      i_rgb valid
//   i_pattern    colour-bar frame request (HDMI_VTG_TEST_PATTERN_EN only)
//   o_ready      pixel requested this cycle (combinational)
//   o_rgb        registered pixel to the encoders
//   o_de         data enable
//   o_hsync      horizontal sync
//   o_vsync      vertical sync
//   o_x, o_y     position of the current output pixel
//   o_sof        one-cycle pulse with pixel (0,0)
//   o_running    high while the generator is not idle
//   o_underflow  sticky flag, cleared only by rst
module hdmi_video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic [23:0]      i_rgb,
  input  logic             i_valid,
`ifdef HDMI_VTG_TEST_PATTERN_EN
  input  logic             i_pattern,
`endif
  output logic             o_ready,
  output logic [23:0]      o_rgb,
  output logic             o_de,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_sof,
  output logic             o_running,
  output logic             o_underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic [CNT_W-1:0] h_adv, v_adv;
  logic             h_last, v_last;
  logic             active, hs, vs, running;
  logic             pat_frame;

  logic [23:0]      o_rgb_q, o_rgb_d;
  logic             o_de_q, o_de_d;
  logic             o_hsync_q, o_hsync_d;
  logic             o_vsync_q, o_vsync_d;
  logic [CNT_W-1:0] o_x_q, o_x_d;
  logic [CNT_W-1:0] o_y_q, o_y_d;
  logic             o_sof_q, o_sof_d;
  logic             o_running_q, o_running_d;
  logic             o_underflow_q, o_underflow_d;

`ifdef HDMI_VTG_TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_W_C = CNT_W'(H_ACTIVE / 8);

  logic             pattern_q, pattern_d;
  logic [CNT_W-1:0] bar_idx;
  logic [23:0]      bar_rgb;

  // i_pattern is taken at (0,0) and then held for the rest of the frame.
  always_comb begin
    pat_frame = (h_q == '0 && v_q == '0) ? i_pattern : pattern_q;
    pattern_d = pat_frame;
    bar_idx   = h_q / BAR_W_C;
    case (bar_idx)
      CNT_W'(0): bar_rgb = 24'hFFFFFF;
      CNT_W'(1): bar_rgb = 24'hFFFF00;
      CNT_W'(2): bar_rgb = 24'h00FFFF;
      CNT_W'(3): bar_rgb = 24'h00FF00;
      CNT_W'(4): bar_rgb = 24'hFF00FF;
      CNT_W'(5): bar_rgb = 24'hFF0000;
      CNT_W'(6): bar_rgb = 24'h0000FF;
      default:   bar_rgb = 24'h000000;
    endcase
  end
`else
  assign pat_frame = 1'b0;
`endif

  always_comb begin
    h_last  = (h_q == H_LAST_C);
    v_last  = (v_q == V_LAST_C);
    h_adv   = h_last ? '0 : h_q + 1'b1;
    v_adv   = h_last ? (v_last ? '0 : v_q + 1'b1) : v_q;
    active  = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    hs      = (h_q >= HS_BEG_C) && (h_q < HS_END_C);
    vs      = (v_q >= VS_BEG_C) && (v_q < VS_END_C);
    running = (state_q != IDLE);
    o_ready = running && active && !pat_frame;

    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    unique case (state_q)
      IDLE: begin
        h_d = '0;
        v_d = '0;
        if (i_enable) state_d = RUN;
      end
      RUN: begin
        h_d = h_adv;
        v_d = v_adv;
        if (!i_enable) state_d = STOPPING;
      end
      STOPPING: begin
        h_d = h_adv;
        v_d = v_adv;
        // Only leave at the very last pixel so a frame is never cut short.
        if (i_enable)                state_d = RUN;
        else if (h_last && v_last)   state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        h_d     = '0;
        v_d     = '0;
      end
    endcase

    if (running) begin
      o_de_d    = active;
      o_hsync_d = hs ? HSYNC_POL : ~HSYNC_POL;
      o_vsync_d = vs ? VSYNC_POL : ~VSYNC_POL;
      o_x_d     = h_q;
      o_y_d     = v_q;
      o_sof_d   = (h_q == '0) && (v_q == '0);
      o_rgb_d   = (o_ready && i_valid) ? i_rgb : '0;
`ifdef HDMI_VTG_TEST_PATTERN_EN
      if (pat_frame && active) o_rgb_d = bar_rgb;
`endif
    end else begin
      o_de_d    = 1'b0;
      o_hsync_d = ~HSYNC_POL;
      o_vsync_d = ~VSYNC_POL;
      o_x_d     = '0;
      o_y_d     = '0;
      o_sof_d   = 1'b0;
      o_rgb_d   = '0;
    end
    o_running_d   = running;
    o_underflow_d = o_underflow_q || (o_ready && !i_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      h_q           <= '0;
      v_q           <= '0;
      o_rgb_q       <= '0;
      o_de_q        <= 1'b0;
      o_hsync_q     <= ~HSYNC_POL;
      o_vsync_q     <= ~VSYNC_POL;
      o_x_q         <= '0;
      o_y_q         <= '0;
      o_sof_q       <= 1'b0;
      o_running_q   <= 1'b0;
      o_underflow_q <= 1'b0;
`ifdef HDMI_VTG_TEST_PATTERN_EN
      pattern_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      o_rgb_q       <= o_rgb_d;
      o_de_q        <= o_de_d;
      o_hsync_q     <= o_hsync_d;
      o_vsync_q     <= o_vsync_d;
      o_x_q         <= o_x_d;
      o_y_q         <= o_y_d;
      o_sof_q       <= o_sof_d;
      o_running_q   <= o_running_d;
      o_underflow_q <= o_underflow_d;
`ifdef HDMI_VTG_TEST_PATTERN_EN
      pattern_q     <= pattern_d;
`endif
    end
  end

  assign o_rgb       = o_rgb_q;
  assign o_de        = o_de_q;
  assign o_hsync     = o_hsync_q;
  assign o_vsync     = o_vsync_q;
  assign o_x         = o_x_q;
  assign o_y         = o_y_q;
  assign o_sof       = o_sof_q;
  assign o_running   = o_running_q;
  assign o_underflow = o_underflow_q;

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Directed bench for hdmi_video_timing_gen using a small 14x7 raster.
module tb_hdmi_video_timing_gen;

  localparam int HT    = 14;
  localparam int VT    = 7;
  localparam int FRAME = HT * VT;
  localparam int NV    = 2 * FRAME;

  logic        clk = 1'b0;
  logic        rst, i_enable, i_valid;
  logic [23:0] i_rgb;
  logic        o_ready, o_de, o_hsync, o_vsync, o_sof, o_running, o_underflow;
  logic [23:0] o_rgb;
  logic [3:0]  o_x, o_y;
`ifdef HDMI_VTG_TEST_PATTERN_EN
  logic        i_pattern;
`endif

  hdmi_video_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_rgb(i_rgb), .i_valid(i_valid),
`ifdef HDMI_VTG_TEST_PATTERN_EN
    .i_pattern(i_pattern),
`endif
    .o_ready(o_ready), .o_rgb(o_rgb), .o_de(o_de), .o_hsync(o_hsync),
    .o_vsync(o_vsync), .o_x(o_x), .o_y(o_y), .o_sof(o_sof),
    .o_running(o_running), .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [23:0] rgb;
    logic        exp_ready;
    logic        exp_de;
    logic        exp_hs;
    logic        exp_vs;
    logic        exp_sof;
    logic [3:0]  exp_x;
    logic [3:0]  exp_y;
    logic [23:0] exp_rgb;
    logic        exp_uf;
  } vec_t;

  vec_t tbl [NV];

  int checks = 0;
  int errors = 0;
  int n_acc, de_f0, de_l0, cyc;
  logic found;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input int idx);
    chk({tag, "_de"},      idx, 32'(o_de),      32'd0);
    chk({tag, "_hsync"},   idx, 32'(o_hsync),   32'd0);
    chk({tag, "_vsync"},   idx, 32'(o_vsync),   32'd0);
    chk({tag, "_running"}, idx, 32'(o_running), 32'd0);
    chk({tag, "_x"},       idx, 32'(o_x),       32'd0);
    chk({tag, "_y"},       idx, 32'(o_y),       32'd0);
    chk({tag, "_sof"},     idx, 32'(o_sof),     32'd0);
    chk({tag, "_rgb"},     idx, 32'(o_rgb),     32'd0);
    chk({tag, "_ready"},   idx, 32'(o_ready),   32'd0);
  endtask

`ifdef HDMI_VTG_TEST_PATTERN_EN
  logic [23:0] bars [8];
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    i_enable = 1'b0;
    i_valid  = 1'b0;
    i_rgb    = '0;
`ifdef HDMI_VTG_TEST_PATTERN_EN
    i_pattern = 1'b0;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

    // Two frames of expected outputs; pixel (3,1) of frame 0 is starved.
    n_acc = 0;
    for (int k = 0; k < NV; k++) begin
      int   x, y;
      logic act;
      x   = k % HT;
      y   = (k / HT) % VT;
      act = (x < 8) && (y < 4);
      tbl[k].valid     = (k != 17);
      tbl[k].rgb       = act ? 24'hA00000 + 24'(n_acc) : 24'h5A5A5A;
      tbl[k].exp_ready = act;
      tbl[k].exp_de    = act;
      tbl[k].exp_hs    = (x == 10) || (x == 11);
      tbl[k].exp_vs    = (y == 5);
      tbl[k].exp_sof   = (k % FRAME) == 0;
      tbl[k].exp_x     = 4'(x);
      tbl[k].exp_y     = 4'(y);
      tbl[k].exp_rgb   = (act && tbl[k].valid) ? tbl[k].rgb : 24'h0;
      tbl[k].exp_uf    = (k >= 17);
      if (act && tbl[k].valid) n_acc++;
    end

    // Reset, then idle with enable low.
    repeat (3) tick();
    chk_idle("rst", 0);
    chk("rst_uf", 0, 32'(o_underflow), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_idle("idle", i);
    end

    // E0: enable sampled, o_ready rises, registered outputs not yet.
    i_enable = 1'b1;
    tick();
    chk("e0_ready",   0, 32'(o_ready),   32'd1);
    chk("e0_sof",     0, 32'(o_sof),     32'd0);
    chk("e0_de",      0, 32'(o_de),      32'd0);
    chk("e0_running", 0, 32'(o_running), 32'd0);

    de_f0 = 0;
    de_l0 = 0;
    for (int k = 0; k < NV; k++) begin
      i_valid = tbl[k].valid;
      i_rgb   = tbl[k].rgb;
      chk("ready", k, 32'(o_ready), 32'(tbl[k].exp_ready));
      tick();
      chk("de",      k, 32'(o_de),        32'(tbl[k].exp_de));
      chk("hsync",   k, 32'(o_hsync),     32'(tbl[k].exp_hs));
      chk("vsync",   k, 32'(o_vsync),     32'(tbl[k].exp_vs));
      chk("sof",     k, 32'(o_sof),       32'(tbl[k].exp_sof));
      chk("x",       k, 32'(o_x),         32'(tbl[k].exp_x));
      chk("y",       k, 32'(o_y),         32'(tbl[k].exp_y));
      chk("rgb",     k, 32'(o_rgb),       32'(tbl[k].exp_rgb));
      chk("uf",      k, 32'(o_underflow), 32'(tbl[k].exp_uf));
      chk("running", k, 32'(o_running),   32'd1);
      if (k < FRAME && o_de) de_f0++;
      if (k < HT && o_de) de_l0++;
    end
    chk("de_per_line",  0, 32'(de_l0), 32'd8);
    chk("de_per_frame", 0, 32'(de_f0), 32'd32);

    // Stop request at (2,1): the frame must finish through (13,6).
    i_valid = 1'b1;
    i_rgb   = 24'h123456;
    repeat (16) tick();
    i_enable = 1'b0;
    for (int i = 0; i < 82; i++) begin
      tick();
      if (i == 0) begin
        chk("stop_first_x",  i, 32'(o_x),       32'd2);
        chk("stop_first_y",  i, 32'(o_y),       32'd1);
        chk("stop_first_de", i, 32'(o_de),      32'd1);
        chk("stop_first_run", i, 32'(o_running), 32'd1);
      end
    end
    chk("stop_last_x",   0, 32'(o_x),       32'd13);
    chk("stop_last_y",   0, 32'(o_y),       32'd6);
    chk("stop_last_run", 0, 32'(o_running), 32'd1);
    chk("stop_last_vs",  0, 32'(o_vsync),   32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle("stopped", i);
      chk("uf_sticky", i, 32'(o_underflow), 32'd1);
    end

    // Restart, stop at (2,1), resume at (0,3): frame period unchanged.
    i_enable = 1'b1;
    tick();
    tick();
    chk("restart_sof", 0, 32'(o_sof), 32'd1);
    repeat (15) tick();
    i_enable = 1'b0;
    repeat (26) tick();
    chk("resume_x",   0, 32'(o_x),       32'd13);
    chk("resume_y",   0, 32'(o_y),       32'd2);
    chk("resume_run", 0, 32'(o_running), 32'd1);
    i_enable = 1'b1;
    cyc   = 41;
    found = 1'b0;
    while (!found && cyc < 300) begin
      tick();
      cyc++;
      if (o_sof) found = 1'b1;
    end
    chk("sof_period", 0, 32'(cyc), 32'd98);

    // Reset in the middle of a frame.
    repeat (20) tick();
    i_enable = 1'b0;
    rst = 1'b1;
    tick();
    chk_idle("midrst", 0);
    chk("midrst_uf", 0, 32'(o_underflow), 32'd0);
    rst = 1'b0;
    tick();
    chk_idle("midrst", 1);

`ifdef HDMI_VTG_TEST_PATTERN_EN
    // Colour bars with no valid data: no requests, no underflow.
    i_pattern = 1'b1;
    i_valid   = 1'b0;
    i_rgb     = 24'h777777;
    i_enable  = 1'b1;
    tick();
    for (int x = 0; x < 8; x++) begin
      chk("pat_ready", x, 32'(o_ready), 32'd0);
      tick();
      chk("pat_rgb", x, 32'(o_rgb), 32'(bars[x]));
      chk("pat_de",  x, 32'(o_de),  32'd1);
    end
    chk("pat_uf", 0, 32'(o_underflow), 32'd0);
    i_enable = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
